// File: rtl/morph_pkg.sv
// -----------------------------------------------------------------------------
// morph_pkg
// Shared definitions for the binary 3x3 morphology blocks (dilation, erosion).
//   morph_state_t : pipeline phase of a streaming 3x3 window operator
//     ST_FILL  - priming the two line buffers, no outputs yet
//     ST_RUN   - one output per accepted input
//     ST_FLUSH - input closed, draining the last WIDTH+1 outputs with zeros
// -----------------------------------------------------------------------------
package morph_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } morph_state_t;

endpackage

// File: rtl/dilation_if.sv
// -----------------------------------------------------------------------------
// dilation_if
// Pixel stream bundle for the morphology blocks.
//   in_write  : source -> block, input pixel valid
//   in_pixel  : source -> block, binary pixel in raster order
//   in_ready  : block -> source, pixel accepted when in_write && in_ready
//   out_read  : block -> sink, one-cycle strobe per output pixel
//   out_pixel : block -> sink, binary result pixel in raster order
// Handshake: an input pixel transfers on a rising edge where in_write and
// in_ready are both 1; there is no output back-pressure, the sink must take
// out_pixel in every cycle where out_read is 1.
// -----------------------------------------------------------------------------
interface dilation_if;
  logic in_write;
  logic in_pixel;
  logic in_ready;
  logic out_read;
  logic out_pixel;

  // Pixel source / result sink side.
  modport master (
    output in_write,
    output in_pixel,
    input  in_ready,
    input  out_read,
    input  out_pixel
  );

  // Morphology block side.
  modport slave (
    input  in_write,
    input  in_pixel,
    output in_ready,
    output out_read,
    output out_pixel
  );
endinterface

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One-bit, DEPTH-deep shift register used as a single image-row delay.
//   clock   : rising-edge clock
//   reset   : synchronous active-high clear of all taps
//   i_shift : advance the delay line by one position
//   i_bit   : bit entering the line
//   o_bit   : bit that entered DEPTH shifts ago
// -----------------------------------------------------------------------------
module line_buffer #(
  parameter int DEPTH = 640
) (
  input  logic clock,
  input  logic reset,
  input  logic i_shift,
  input  logic i_bit,
  output logic o_bit
);

  logic [DEPTH-1:0] r_taps;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_taps <= '0;
    end else if (i_shift) begin
      r_taps <= {r_taps[DEPTH-2:0], i_bit};
    end
  end

  assign o_bit = r_taps[DEPTH-1];

endmodule

// File: rtl/dilation.sv
// -----------------------------------------------------------------------------
// dilation
// Streaming binary 3x3 dilation (OR of the neighbourhood, zero outside frame).
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset, discards any partial frame
//   in_write  : input pixel valid
//   in_pixel  : binary input pixel, raster order
//   in_ready  : block accepts in_pixel this cycle
//   out_read  : output pixel valid, one-cycle strobe
//   out_pixel : registered dilated pixel, raster order
//   dbg_state : current pipeline phase (observation only)
// Handshake: input transfers when in_write && in_ready at a rising edge;
// outputs are strobed with out_read and cannot be stalled by the sink.
//
// Window layout: when input index n is accepted, the incoming column is
// {row-2, row-1, row} = {lb_top, lb_mid, in_pixel} = pixels n-2W, n-W, n.
// r_win0 / r_win1 hold the columns of n-1 and n-2, so the window centre is
// pixel n-W-1, which is the output produced by this acceptance.
// -----------------------------------------------------------------------------
module dilation
  import morph_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_write,
  input  logic         in_pixel,
  output logic         in_ready,
  output logic         out_read,
  output logic         out_pixel,
  output morph_state_t dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  morph_state_t  r_state;
  morph_state_t  w_state_next;

  logic [CW-1:0] r_in_col;
  logic [RW-1:0] r_in_row;
  logic [CW-1:0] r_out_col;
  logic [RW-1:0] r_out_row;

  logic [2:0]    r_win0;      // column of pixel n-1, bit2 = top row
  logic [2:0]    r_win1;      // column of pixel n-2
  logic [2:0]    w_col_new;   // column of pixel n (incoming)

  logic          r_out_read;
  logic          r_out_pixel;

  logic          w_accept;
  logic          w_flush;
  logic          w_shift;
  logic          w_emit;
  logic          w_din;
  logic          w_lb_mid;
  logic          w_lb_top;
  logic          w_in_last;
  logic          w_out_last;
  logic          w_fill_done;

  logic [2:0]    w_left;
  logic [2:0]    w_right;
  logic [2:0]    w_row_mask;
  logic          w_dilated;

  // ---------------------------------------------------------------------------
  // Handshake and pipeline advance
  // ---------------------------------------------------------------------------
  // in_ready is gated by reset directly so it reads 0 for the whole reset
  // pulse and 1 in the very first cycle after reset drops.
  assign in_ready = ~reset & (r_state != ST_FLUSH);
  assign w_accept = in_write & in_ready;
  assign w_flush  = (r_state == ST_FLUSH);

  // During flush the pipeline keeps moving, fed with zeros below the frame.
  assign w_shift  = w_accept | w_flush;
  assign w_din    = w_flush ? 1'b0 : in_pixel;
  assign w_emit   = ((r_state == ST_RUN) & w_accept) | w_flush;

  assign w_in_last   = (r_in_col == COL_LAST) && (r_in_row == ROW_LAST);
  assign w_out_last  = (r_out_col == COL_LAST) && (r_out_row == ROW_LAST);
  // Input index WIDTH is row 1, column 0.
  assign w_fill_done = (r_in_row == ROW_ONE) && (r_in_col == '0);

  // ---------------------------------------------------------------------------
  // Row delays
  // ---------------------------------------------------------------------------
  line_buffer #(.DEPTH(WIDTH)) u_lb_mid (
    .clock   (clock),
    .reset   (reset),
    .i_shift (w_shift),
    .i_bit   (w_din),
    .o_bit   (w_lb_mid)
  );

  line_buffer #(.DEPTH(WIDTH)) u_lb_top (
    .clock   (clock),
    .reset   (reset),
    .i_shift (w_shift),
    .i_bit   (w_lb_mid),
    .o_bit   (w_lb_top)
  );

  assign w_col_new = {w_lb_top, w_lb_mid, w_din};

  // ---------------------------------------------------------------------------
  // Edge masking and OR reduction, keyed on the output pixel's coordinates.
  // Masking also hides stale data from the previous frame and the wrap from
  // one row end to the next row start.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_left     = r_win1;
    w_right    = w_col_new;
    w_row_mask = 3'b111;
    if (r_out_col == '0)      w_left        = 3'b000;
    if (r_out_col == COL_LAST) w_right      = 3'b000;
    if (r_out_row == '0)      w_row_mask[2] = 1'b0;
    if (r_out_row == ROW_LAST) w_row_mask[0] = 1'b0;
    w_dilated = |((w_left | r_win0 | w_right) & w_row_mask);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FILL:  if (w_accept && w_fill_done) w_state_next = ST_RUN;
      ST_RUN:   if (w_accept && w_in_last)   w_state_next = ST_FLUSH;
      ST_FLUSH: if (w_out_last)              w_state_next = ST_FILL;
      default:                               w_state_next = ST_FILL;
    endcase
  end

  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Counters, window and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_col    <= '0;
      r_in_row    <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_win0      <= '0;
      r_win1      <= '0;
      r_out_read  <= 1'b0;
      r_out_pixel <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_in_col == COL_LAST) begin
          r_in_col <= '0;
          r_in_row <= (r_in_row == ROW_LAST) ? '0 : r_in_row + ROW_ONE;
        end else begin
          r_in_col <= r_in_col + COL_ONE;
        end
      end

      if (w_emit) begin
        if (r_out_col == COL_LAST) begin
          r_out_col <= '0;
          r_out_row <= (r_out_row == ROW_LAST) ? '0 : r_out_row + ROW_ONE;
        end else begin
          r_out_col <= r_out_col + COL_ONE;
        end
        r_out_pixel <= w_dilated;
      end

      if (w_shift) begin
        r_win1 <= r_win0;
        r_win0 <= w_col_new;
      end

      r_out_read <= w_emit;
    end
  end

  assign out_read  = r_out_read;
  assign out_pixel = r_out_pixel;

endmodule
